// File: rtl/labcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : labcpu_pkg
// Description : Shared definitions for the LABCPU fetch slice: default
//               instruction/address widths, fetch-count width and the
//               fetch state machine encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package labcpu_pkg;

    localparam int unsigned c_DATA_WIDTH = 16;
    localparam int unsigned c_ADDR_WIDTH = 10;
    localparam int unsigned c_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/labcpu_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : labcpu_fetch_buf
// Description : Two-entry FIFO holding fetched {pc, instruction} entries.
//               Flush has priority over push/pop; simultaneous push and pop
//               keep the occupancy constant.
// Ports       : i_w_clk, i_w_reset_n (async, active low)
//               i_w_flush  - discard all entries
//               i_w_push   - write i_w_data at the tail
//               i_w_pop    - drop the head entry
//               o_w_head   - current head entry (meaningful when count != 0)
//               o_w_count  - occupancy 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module labcpu_fetch_buf #(
    parameter int p_width = 26
) (
    input  logic               i_w_clk,
    input  logic               i_w_reset_n,
    input  logic               i_w_flush,
    input  logic               i_w_push,
    input  logic [p_width-1:0] i_w_data,
    input  logic               i_w_pop,
    output logic [p_width-1:0] o_w_head,
    output logic [1:0]         o_w_count
);

    logic [p_width-1:0] r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_w_push && (r_count != 2'd2);
    assign w_pop  = i_w_pop  && (r_count != 2'd0);

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_w_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the consumer only looks at it when count != 0.
    always_ff @(posedge i_w_clk) begin
        if (w_push && !i_w_flush) begin
            r_mem[r_wr_ptr] <= i_w_data;
        end
    end

    assign o_w_head  = r_mem[r_rd_ptr];
    assign o_w_count = r_count;

endmodule
`default_nettype wire

// File: rtl/labcpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : labcpu_fetch
// Description : Instruction fetch unit. Issues one read per cycle into a
//               1-cycle-latency instruction memory, buffers up to two
//               instructions and hands them to decode with valid/ready.
//               Supports redirect (branch/jump) and a level halt.
// Ports       : i_w_clk, i_w_reset_n (async, active low)
//               o_w_mem_addr/o_w_mem_rd/i_w_mem_data - instruction memory
//               o_w_instr/o_w_pc/o_w_valid/i_w_ready  - decode handshake
//               i_w_redirect/i_w_target               - control flow change
//               i_w_halt                              - suspend new reads
//               o_w_fetch_count (only with LABCPU_FETCH_CNT_EN defined)
// Options     : LABCPU_FETCH_CNT_EN - adds a 16-bit accepted-transfer counter
// Revision    : 1.0 - initial release
// ============================================================================
module labcpu_fetch
    import labcpu_pkg::*;
#(
    parameter int p_data_width    = c_DATA_WIDTH,
    parameter int p_address_width = c_ADDR_WIDTH
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset_n,
    output logic [p_address_width-1:0] o_w_mem_addr,
    output logic                       o_w_mem_rd,
    input  logic [p_data_width-1:0]    i_w_mem_data,
    output logic [p_data_width-1:0]    o_w_instr,
    output logic [p_address_width-1:0] o_w_pc,
    output logic                       o_w_valid,
    input  logic                       i_w_ready,
    input  logic                       i_w_redirect,
    input  logic [p_address_width-1:0] i_w_target,
    input  logic                       i_w_halt
`ifdef LABCPU_FETCH_CNT_EN
    ,
    output logic [c_CNT_WIDTH-1:0]     o_w_fetch_count
`endif
);

    localparam int c_ENTRY_W = p_address_width + p_data_width;
    localparam logic [p_address_width-1:0] c_PC_ONE = {{(p_address_width-1){1'b0}}, 1'b1};

    fetch_state_t               r_state;
    fetch_state_t               w_state_nxt;
    logic [p_address_width-1:0] r_pc;
    logic [p_address_width-1:0] r_infl_pc;
    logic                       r_infl;
    logic [1:0]                 w_count;
    logic [c_ENTRY_W-1:0]       w_head;
    logic                       w_buf_empty;
    logic                       w_bypass;
    logic                       w_valid;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_issue;
    logic [2:0]                 w_occ;

    // Returning read data is presented directly when the buffer is empty so
    // a read reaches decode in the cycle its data arrives; it is captured into
    // the buffer only if decode does not take it right away.
    assign w_buf_empty = (w_count == 2'd0);
    assign w_bypass    = w_buf_empty && r_infl;
    assign w_valid     = !w_buf_empty || r_infl;
    assign w_pop       = !w_buf_empty && i_w_ready;
    assign w_push      = r_infl && !(w_bypass && i_w_ready);
    assign w_occ       = {1'b0, w_count} + {2'b00, r_infl};

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // A read in a redirect cycle would be for the abandoned path.
                w_issue = (w_occ < 3'd2) && !i_w_redirect;
                if (i_w_halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!i_w_halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            r_pc      <= '0;
            r_infl    <= 1'b0;
            r_infl_pc <= '0;
        end else begin
            r_infl    <= w_issue;
            r_infl_pc <= r_pc;
            if (i_w_redirect) begin
                r_pc <= i_w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + c_PC_ONE;
            end
        end
    end

    labcpu_fetch_buf #(
        .p_width (c_ENTRY_W)
    ) u_buf (
        .i_w_clk     (i_w_clk),
        .i_w_reset_n (i_w_reset_n),
        .i_w_flush   (i_w_redirect),
        .i_w_push    (w_push),
        .i_w_data    ({r_infl_pc, i_w_mem_data}),
        .i_w_pop     (w_pop),
        .o_w_head    (w_head),
        .o_w_count   (w_count)
    );

    // ------------------------------------------------------------------
    // Decode-side outputs (zero whenever nothing is valid)
    // ------------------------------------------------------------------
    always_comb begin
        o_w_instr = '0;
        o_w_pc    = '0;
        if (!w_buf_empty) begin
            {o_w_pc, o_w_instr} = w_head;
        end else if (r_infl) begin
            o_w_pc    = r_infl_pc;
            o_w_instr = i_w_mem_data;
        end
    end

    assign o_w_valid    = w_valid;
    assign o_w_mem_rd   = w_issue;
    assign o_w_mem_addr = r_pc;

`ifdef LABCPU_FETCH_CNT_EN
    logic                   w_xfer;
    logic [c_CNT_WIDTH-1:0] r_fetch_count;

    assign w_xfer = w_valid && i_w_ready;

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            r_fetch_count <= '0;
        end else if (w_xfer) begin
            r_fetch_count <= r_fetch_count + {{(c_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_w_fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: doc/labcpu_fetch.md
LABCPU_FETCH -- requirements
Module: labcpu_fetch

Interface
REQ-001 SHALL have parameter p_data_width, default 16, instruction word width.
REQ-002 SHALL have parameter p_address_width, default 10, program-counter and instruction-memory address width.
REQ-003 SHALL have port i_w_clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_w_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port o_w_mem_addr, output, p_address_width, instruction-memory read address.
REQ-006 SHALL have port o_w_mem_rd, output, 1, read strobe; memory returns data exactly 1 cycle later.
REQ-007 SHALL have port i_w_mem_data, input, p_data_width, read data, valid in the cycle after o_w_mem_rd.
REQ-008 SHALL have port o_w_instr, output, p_data_width, instruction to the CPU decode stage.
REQ-009 SHALL have port o_w_pc, output, p_address_width, address of o_w_instr.
REQ-010 SHALL have port o_w_valid, output, 1, o_w_instr/o_w_pc valid.
REQ-011 SHALL have port i_w_ready, input, 1, decode accepts; transfer when o_w_valid & i_w_ready.
REQ-012 SHALL have port i_w_redirect, input, 1, taken branch/jump from the CPU.
REQ-013 SHALL have port i_w_target, input, p_address_width, redirect address.
REQ-014 SHALL have port i_w_halt, input, 1, level; suspends new reads.

Function
REQ-015 SHALL hold a 2-entry instruction buffer plus at most 1 in-flight read; a read is issued only when occupancy + in-flight < 2.
REQ-016 SHALL issue one read per cycle at fetch PC and increment PC by 1 on each issue, wrapping 2^p_address_width-1 -> 0.
REQ-017 SHALL present the buffer head on o_w_instr/o_w_pc with o_w_valid high while the buffer is non-empty; outputs stable while valid & !ready.
REQ-018 SHALL sustain 1 instruction/cycle with i_w_ready held high.
REQ-019 SHALL run a state machine IDLE -> RUN (first cycle after reset release), RUN <-> HALT (on i_w_halt level); redirect is legal in every state.
REQ-020 SHALL on i_w_redirect: complete a same-cycle transfer, discard all other buffered entries and the in-flight read, load PC with i_w_target; o_w_valid is low the next cycle; read at target issues the next cycle (RUN) and appears on o_w_valid 2 cycles after redirect.
REQ-021 SHALL in HALT issue no reads, still capture an in-flight read and let the buffer drain; on halt release, resume reads the next cycle from the current PC.
REQ-022 SHALL give redirect priority over halt for PC update; a redirect while halted updates PC only.
REQ-023 SHALL have first-instruction latency: reset release edge -> read of address 0 at cycle 1 -> o_w_valid at cycle 2.

Reset
REQ-024 SHALL on i_w_reset_n low, immediately: PC=0, buffer empty, in-flight cleared, state IDLE, o_w_valid=0, o_w_mem_rd=0, o_w_mem_addr=0, o_w_instr=0, o_w_pc=0.
REQ-025 SHALL on reset mid-operation discard all state; no read data returning after reset is captured.

Configuration
REQ-026 SHALL, with LABCPU_FETCH_CNT_EN defined, add output o_w_fetch_count (16 bits, reset 0, +1 per accepted transfer, wraps 0xFFFF->0); without it, port and counter absent, otherwise identical.

Structure
REQ-027 SHALL take width defaults and the IDLE/RUN/HALT state encoding from shared package labcpu_pkg.
REQ-028 SHALL implement the 2-entry buffer as sub-module labcpu_fetch_buf (push/pop/flush, count output).

Verification
REQ-029 Reset release, ready=1, memory mem[a]=a+0x100 -> valid at cycle 2 with pc 0/instr 0x0100, then pc 1,2,3... one per cycle.
REQ-030 Ready low 5 cycles from steady stream -> at most 2 buffered, o_w_mem_rd low, head held unchanged; on ready high no instruction lost or duplicated.
REQ-031 Redirect to 0x200 while pc 5 presented and accepted -> pc 5 transferred, next valid pc 0x200 two cycles later, pcs 6/7 never appear.
REQ-032 PC at 0x3FF with p_address_width=10 -> next fetched pc 0x000.
REQ-033 Halt 4 cycles with ready=1 -> buffer drains, valid low, no reads; release -> next pc continuous.
REQ-034 Reset asserted with in-flight read and full buffer -> all outputs 0 immediately; after release fetch restarts at pc 0; with LABCPU_FETCH_CNT_EN count = accepted transfers.
